// File: rtl/pe_seq_pkg.sv
// Shared constants, state encoding and width helpers for the PE-array sequencer.
package pe_seq_pkg;

  localparam int NPE      = 4;
  localparam int ROWS     = 64;
  localparam int COLS     = 64;
  localparam int WCOUNT   = 4;
  localparam int PE_ACC_W = 14;
  localparam int CHUNKS   = COLS / WCOUNT;
  localparam int GROUPS   = ROWS / NPE;

  function automatic int clog2_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int addr_width(input int groups, input int chunks);
    return clog2_w(groups) + clog2_w(chunks);
  endfunction

  localparam int GRP_W  = clog2_w(GROUPS);
  localparam int CHK_W  = clog2_w(CHUNKS);
  localparam int ADDR_W = addr_width(GROUPS, CHUNKS);
  localparam int XW     = WCOUNT * 4;
  localparam int VEC_W  = COLS * 4;
  localparam int RES_W  = NPE * PE_ACC_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FETCH = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/pe_array_seq.sv
// Sequencer for the heavy-hash matrix-vector multiply: walks the matrix memory
// group by group, feeds the parent's PE array and hands back each group's dot-products.
module pe_array_seq
  import pe_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_vec,
  input  logic              abort,
  output logic              m_rd,
  output logic [ADDR_W-1:0] m_addr,
  output logic              pe_en,
  output logic              pe_clr,
  output logic [XW-1:0]     x_chunk,
  input  logic [RES_W-1:0]  pe_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [GRP_W-1:0]  res_group,
  output logic              done
);

  state_t             state_reg, state_next;
  logic [GRP_W-1:0]   group_reg, group_next;
  logic [CHK_W-1:0]   chunk_reg, chunk_next;
  logic               drain_reg, drain_next;
  logic [VEC_W-1:0]   vec_reg;
  logic               pe_en_reg;
  logic [XW-1:0]      x_chunk_reg;
  logic               abort_clr_reg;

  logic               abort_act;
  logic               accept;
  logic               last_group;
  logic [XW-1:0]      chunk_slice;

  assign abort_act   = abort && (state_reg != S_IDLE);
  assign accept      = (state_reg == S_IDLE) && in_valid;
  assign last_group  = (group_reg == GRP_W'(GROUPS - 1));
  assign chunk_slice = vec_reg[int'(chunk_reg) * XW +: XW];

  always_comb begin
    state_next = state_reg;
    group_next = group_reg;
    chunk_next = chunk_reg;
    drain_next = drain_reg;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          state_next = S_CLR;
          group_next = '0;
        end
      end
      S_CLR: begin
        state_next = S_FETCH;
        chunk_next = '0;
      end
      S_FETCH: begin
        chunk_next = chunk_reg + 1'b1;
        if (chunk_reg == CHK_W'(CHUNKS - 1)) begin
          state_next = S_DRAIN;
          drain_next = 1'b0;
        end
      end
      S_DRAIN: begin
        drain_next = 1'b1;
        if (drain_reg) state_next = S_OUT;
      end
      S_OUT: begin
        if (res_ready) begin
          if (last_group) begin
            state_next = S_IDLE;
          end else begin
            group_next = group_reg + 1'b1;
            state_next = S_CLR;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (abort_act) state_next = S_IDLE;
  end

  // Align register: memory data lags m_rd by one cycle, so enable and vector
  // slice are delayed by the same amount. The second DRAIN cycle adds a zero
  // chunk purely to push the last product through the PE multiply stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      group_reg     <= '0;
      chunk_reg     <= '0;
      drain_reg     <= 1'b0;
      vec_reg       <= '0;
      pe_en_reg     <= 1'b0;
      x_chunk_reg   <= '0;
      abort_clr_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      group_reg     <= group_next;
      chunk_reg     <= chunk_next;
      drain_reg     <= drain_next;
      if (accept) vec_reg <= in_vec;
      pe_en_reg     <= !abort_act &&
                       ((state_reg == S_FETCH) || (state_reg == S_DRAIN && !drain_reg));
      x_chunk_reg   <= (state_reg == S_FETCH && !abort_act) ? chunk_slice : '0;
      abort_clr_reg <= abort_act;
    end
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign m_rd      = (state_reg == S_FETCH);
  assign m_addr    = m_rd ? {group_reg, chunk_reg} : '0;
  assign pe_en     = pe_en_reg;
  assign x_chunk   = x_chunk_reg;
  assign pe_clr    = (state_reg == S_CLR) || abort_clr_reg;
  assign res_valid = (state_reg == S_OUT);
  assign res_data  = res_valid ? pe_out : '0;
  assign res_group = res_valid ? group_reg : '0;
  assign done      = (state_reg == S_OUT) && res_ready && last_group && !abort;

endmodule

// File: tb/tb_pe_array_seq.sv
// Self-checking bench for pe_array_seq with a behavioural matrix memory and PE array.
module tb_pe_array_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         abort = 1'b0;
  logic         res_ready = 1'b0;
  logic [255:0] in_vec = '0;
  logic         in_ready, m_rd, pe_en, pe_clr, res_valid, done;
  logic [7:0]   m_addr;
  logic [15:0]  x_chunk;
  logic [55:0]  pe_out, res_data;
  logic [3:0]   res_group;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [3:0]  group;
    logic [55:0] data;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int           mode;
    logic [255:0] vec;
    int           exp_lane;
  } vec_t;
  vec_t tests[4];

  logic [63:0] mat [256];
  logic [63:0] mem_q = '0;
  logic [13:0] acc [4];
  logic [9:0]  mul [4];

  always #5 clk = ~clk;

  pe_array_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .abort(abort), .m_rd(m_rd), .m_addr(m_addr),
    .pe_en(pe_en), .pe_clr(pe_clr), .x_chunk(x_chunk), .pe_out(pe_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_group(res_group), .done(done)
  );

  function automatic logic [9:0] prod(input int i);
    int s = 0;
    for (int w = 0; w < 4; w++)
      s += int'(mem_q[16*i + 4*w +: 4]) * int'(x_chunk[4*w +: 4]);
    return 10'(s);
  endfunction

  // Matrix memory (1-cycle read) and PE array: mul stage then accumulate stage.
  always @(posedge clk) begin
    if (m_rd) mem_q <= mat[m_addr];
    for (int i = 0; i < 4; i++) begin
      if (pe_clr) begin
        acc[i] <= '0;
        mul[i] <= '0;
      end else if (pe_en) begin
        acc[i] <= acc[i] + 14'(mul[i]);
        mul[i] <= prod(i);
      end
    end
  end
  assign pe_out = {acc[3], acc[2], acc[1], acc[0]};

  initial begin
    for (int i = 0; i < 4; i++) begin
      acc[i] = '0;
      mul[i] = '0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_group", res_group, e.group);
        $display("result group=%0d data=%h", res_group, res_data);
      end
    end
  end

  function automatic void set_nib(input int r, input int c, input logic [3:0] v);
    mat[(r/4)*16 + c/4][16*(r%4) + 4*(c%4) +: 4] = v;
  endfunction

  function automatic int ref_dot(input int r, input logic [255:0] v);
    int s = 0;
    for (int c = 0; c < 64; c++)
      s += int'(mat[(r/4)*16 + c/4][16*(r%4) + 4*(c%4) +: 4]) * int'(v[4*c +: 4]);
    return s;
  endfunction

  task automatic fill(input int mode);
    for (int a = 0; a < 256; a++) begin
      case (mode)
        0:       mat[a] = 64'h1111_1111_1111_1111;
        1:       mat[a] = 64'hFFFF_FFFF_FFFF_FFFF;
        3:       mat[a] = {$urandom, $urandom};
        default: mat[a] = '0;
      endcase
    end
    if (mode == 2)
      for (int r = 0; r < 64; r++) set_nib(r, r, 4'd1);
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  task automatic start_vec(input logic [255:0] v, input int exp_lane);
    @(posedge clk); #1;
    in_vec   = v;
    in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_accept", in_ready, 1);
    for (int g = 0; g < 16; g++) begin
      exp_t e;
      e.group = 4'(g);
      for (int i = 0; i < 4; i++) begin
        int lane;
        if (exp_lane >= 0)       lane = exp_lane;
        else if (exp_lane == -1) lane = (4*g + i) % 16;
        else                     lane = ref_dot(4*g + i, v);
        e.data[14*i +: 14] = 14'(lane);
      end
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_vec(input bit timing, input bit noise, input logic [255:0] v);
    int n = 0, first_rd = -1, rd_cnt = 0, en_cnt = 0, d0 = done_cnt;
    bit got = 0;
    while (!got && n < 2000) begin
      @(negedge clk);
      n++;
      if (m_rd) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = n;
      end
      if (pe_en) en_cnt++;
      if (done) got = 1;
      if (noise && n == 5) begin
        in_valid = 1'b1;
        in_vec   = ~v;
      end
      if (noise && n == 200) in_valid = 1'b0;
    end
    chk("done_seen", got, 1);
    if (timing) begin
      chk("first_m_rd_cycle", first_rd, 2);
      chk("done_cycle", n, 320);
      chk("m_rd_cycles", rd_cnt, 256);
      chk("pe_en_cycles", en_cnt, 272);
    end
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_m_rd"}, m_rd, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_pe_en"}, pe_en, 0);
    chk({tag, "_pe_clr"}, pe_clr, 0);
    chk({tag, "_x_chunk"}, x_chunk, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_group"}, res_group, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [255:0] all1, all15, idv, v;
    int bad, n;
    for (int j = 0; j < 64; j++) begin
      all1[4*j +: 4]  = 4'd1;
      all15[4*j +: 4] = 4'd15;
      idv[4*j +: 4]   = 4'(j % 16);
    end
    tests[0] = '{0, all1, 64};
    tests[1] = '{1, all15, 14400};
    tests[2] = '{2, idv, -1};
    tests[3] = '{3, rand_vec(), -2};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      $display("vector test %0d mode %0d", t, tests[t].mode);
      fill(tests[t].mode);
      start_vec(tests[t].vec, tests[t].exp_lane);
      finish_vec(1'b1, t == 3, tests[t].vec);
    end

    // Back-pressure: hold group 0 in OUT for 5 cycles.
    fill(2);
    res_ready = 1'b0;
    start_vec(idv, -1);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_res_valid_rise", res_valid, 1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, exp_q[0].data);
      chk("hold_res_group", res_group, 0);
      chk("hold_m_rd", m_rd, 0);
      chk("hold_pe_en", pe_en, 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    finish_vec(1'b0, 1'b0, idv);

    // Abort during FETCH k=7 of group 0.
    fill(3);
    v = rand_vec();
    start_vec(v, -2);
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_m_rd", m_rd, 1);
    chk("abort_m_addr", m_addr, 7);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_pe_clr", pe_clr, 1);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_pe_en", pe_en, 0);
    exp_q.delete();
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_valid || done || pe_clr) bad++;
    end
    chk("abort_quiet", bad, 0);
    v = rand_vec();
    start_vec(v, -2);
    finish_vec(1'b1, 1'b0, v);

    // Asynchronous reset in the first DRAIN cycle.
    fill(3);
    v = rand_vec();
    start_vec(v, -2);
    repeat (18) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    v = rand_vec();
    start_vec(v, -2);
    finish_vec(1'b1, 1'b0, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_array_seq.md
# pe_array_seq

Sequencer for the heavy-hash matrix–vector multiply. Latches a 64-nibble SHA3 vector, streams matrix words from the matrix memory into an array of NPE multiply-accumulate PEs (4 nibble products per PE per cycle, 14-bit accumulator, 2-stage mul/acc pipeline). Clears, enables and drains the PEs, and returns each group of NPE row dot-products over a valid/ready handshake. Sits between the SHA3 stage and the post-multiply truncate/XOR stage; the PE array is instantiated beside it in the parent.

## Interface
- NPE, 4, PEs driven in parallel (rows per group)
- ROWS, 64, matrix rows; multiple of NPE
- COLS, 64, vector length in 4-bit nibbles; multiple of WCOUNT
- WCOUNT, 4, nibbles consumed per PE per cycle
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  vector offered
- in_ready  out  1  high only in IDLE
- in_vec  in  COLS*4  vector; nibble j = bits [4j+3:4j]
- abort  in  1  synchronous cancel
- m_rd  out  1  matrix read strobe
- m_addr  out  log2(ROWS/NPE)+log2(COLS/WCOUNT)  = group*CHUNKS + k
- pe_en  out  1  to all PEs
- pe_clr  out  1  to all PEs
- x_chunk  out  WCOUNT*4  vector slice, shared by all PEs
- pe_out  in  NPE*14  PE accumulators; PE i at [14i+13:14i]
- res_valid  out  1  group result valid
- res_ready  in  1  consumer accept
- res_data  out  NPE*14  = pe_out while res_valid
- res_group  out  log2(ROWS/NPE)  group index of res_data
- done  out  1  one-cycle pulse after last group accepted

## Operation
- CHUNKS = COLS/WCOUNT (16), GROUPS = ROWS/NPE (16).
- States: IDLE, CLR, FETCH, DRAIN, OUT.
- IDLE: in_ready=1. On in_valid: latch in_vec, group=0 -> CLR.
- CLR, 1 cycle: pe_clr=1 -> FETCH with k=0.
- FETCH, CHUNKS cycles: m_rd=1, m_addr=group*CHUNKS+k, k++. Leaves after k=CHUNKS-1.
- Memory read latency is 1 cycle. pe_en and x_chunk are the 1-cycle-delayed m_rd and nibble slice k, so M and X arrive aligned.
- DRAIN, 2 cycles:
  - Cycle 1 carries the delayed last chunk.
  - Cycle 2: pe_en=1, x_chunk=0. This flushes mul_reg into the accumulator and adds 0.
- OUT: res_valid=1; res_data, res_group held stable until res_ready.
  - On the handshake: if group<GROUPS-1, then group++ -> CLR.
  - Otherwise -> IDLE with done=1 in that cycle.
- abort in any non-IDLE state: next state IDLE, pe_clr=1 for 1 cycle, no done, no further res_valid. abort in IDLE is ignored.
- in_valid outside IDLE is ignored and not latched.
- Width: max row sum = 64×225 = 14400 < 2^14. No saturation logic; widths are fixed.

## Timing
- Reset values: in_ready=1, m_rd=0, m_addr=0, pe_en=0, pe_clr=0, x_chunk=0, res_valid=0, res_data=0, res_group=0, done=0; state IDLE.
- Assertion of rst_n mid-operation returns to IDLE immediately. PEs are cleared by the next CLR.
- Per group, relative to the first FETCH cycle t=0:
  - m_rd is high t=0..15.
  - pe_en is high t=1..17.
  - res_valid rises at t=18.
- Group cost: 1 + CHUNKS + 2 + OUT cycles. Minimum 20; 320 per vector with res_ready tied high.
- Vector acceptance to first m_rd: 2 cycles (IDLE handshake, CLR).
- The next vector can be accepted the cycle after done.
- res_ready high while res_valid is low has no effect.

## Structure
- Package pe_seq_pkg holds:
  - the state enum;
  - localparams CHUNKS, GROUPS, PE_ACC_W=14;
  - address width functions.
- No sub-module. Single FSM with group and chunk counters, a 1-stage align register (pe_en, x_chunk), and the vector register. The PE array stays in the parent.

## Test plan
- Matrix all 1, vector all 1 -> every res_data lane 64; 16 results, res_group 0..15; done once.
- Matrix all 15, vector all 15 -> every lane 14400, no overflow.
- Identity-like pattern (row r nibble r = 1), vector nibble j = j mod 16 -> lane i of group g = (4g+i) mod 16.
- res_ready held low 5 cycles in OUT -> res_valid, res_data, res_group stable; no m_rd or pe_en activity.
- abort asserted at FETCH k=7 -> IDLE next cycle, pe_clr pulse, no res_valid/done. A following vector computes correctly (PEs start from 0).
- rst_n asserted mid-DRAIN -> all outputs at reset values immediately; a new vector runs to correct results.
